stepper_move_ctrl: RTL

Motion sequencer for the external stepper driver. It accepts clockwise and counter-clockwise move requests from the debounced push-button logic and runs a fixed 180° move as STEP/DIR/ENABLE pulses with driver-safe setup, pulse-width and rate timing. It sits between the button front end and the driver pins, and it also drives the DM status LEDs.

---
 rtl/stepper_move_ctrl_if.sv | 26 ++
 rtl/stepper_move_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stepper_move_ctrl_if.sv
// Signal bundle between the button front end, stepper_move_ctrl and the driver pins / status LEDs.
// The slave modport is the sequencer's view; the master modport is the requester and observer view.
interface stepper_move_ctrl_if;
  logic req_cw;
  logic req_ccw;
  logic abort;
  logic step;
  logic dir;
  logic en_n;
  logic busy;
  logic done;
  logic aborted;
  logic red;
  logic green;
  logic blue;

  modport slave (
    input  req_cw, req_ccw, abort,
    output step, dir, en_n, busy, done, aborted, red, green, blue
  );

  modport master (
    output req_cw, req_ccw, abort,
    input  step, dir, en_n, busy, done, aborted, red, green, blue
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Stepper move sequencer: runs a fixed-length move as STEP/DIR/ENABLE pulses with setup,
// pulse-width and rate timing, supports early abort and drives the status LEDs.
module stepper_move_ctrl #(
  parameter int STEPS_180   = 100,
  parameter int STEP_PERIOD = 50000,
  parameter int PULSE_W     = 100,
  parameter int DIR_SETUP   = 250
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  stepper_move_ctrl_if.slave bus
);

  localparam int TMAX    = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int CNT_W   = $clog2(STEPS_180 + 1);

  // Timers count down from duration-1, so a phase lasts exactly its nominal number of cycles.
  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(DIR_SETUP - 1);
  localparam logic [TIMER_W-1:0] HI_LOAD    = TIMER_W'(PULSE_W - 1);
  localparam logic [TIMER_W-1:0] LO_LOAD    = TIMER_W'(STEP_PERIOD - PULSE_W - 1);
  localparam logic [CNT_W-1:0]   STEPS_LOAD = CNT_W'(STEPS_180);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STEP_HI = 3'd2,
    S_STEP_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               dir_q, dir_d;
  logic               aborted_q, aborted_d;
  logic               abort_pend_q, abort_pend_d;
  logic               step_q, step_d;
  logic               en_n_q, en_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               red_q, red_d;
  logic               green_q, green_d;
  logic               blue_q, blue_d;
  logic               timer_zero;

  assign timer_zero = (timer_q == {TIMER_W{1'b0}});

  // Next-state, timer, step counter and latched direction/abort status.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_cw || bus.req_ccw) begin
          state_d      = S_SETUP;
          dir_d        = bus.req_cw;
          timer_d      = SETUP_LOAD;
          remaining_d  = STEPS_LOAD;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (timer_zero) begin
          state_d = S_STEP_HI;
          timer_d = HI_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_STEP_HI: begin
        // An abort seen during the high phase is remembered so the pulse is never cut short.
        if (timer_zero) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (abort_pend_q || bus.abort) begin
            state_d      = S_DONE;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d = S_STEP_LO;
            timer_d = LO_LOAD;
          end
        end else begin
          timer_d      = timer_q - TIMER_W'(1);
          abort_pend_d = abort_pend_q | bus.abort;
        end
      end
      S_STEP_LO: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (timer_zero) begin
          if (remaining_q != {CNT_W{1'b0}}) begin
            state_d = S_STEP_HI;
            timer_d = HI_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        timer_d = {TIMER_W{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so outputs are flops.
  always_comb begin
    step_d  = (state_d == S_STEP_HI);
    busy_d  = (state_d != S_IDLE);
    en_n_d  = ~busy_d;
    done_d  = (state_d == S_DONE);
    green_d = (state_d == S_IDLE);
    blue_d  = busy_d & dir_d;
    red_d   = (busy_d & ~dir_d) | (green_d & aborted_d);
  end

  // State and output registers with asynchronous reset to the idle, driver-disabled condition.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      timer_q      <= {TIMER_W{1'b0}};
      remaining_q  <= {CNT_W{1'b0}};
      dir_q        <= 1'b1;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      step_q       <= 1'b0;
      en_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      red_q        <= 1'b0;
      green_q      <= 1'b1;
      blue_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      step_q       <= step_d;
      en_n_q       <= en_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
  assign bus.en_n    = en_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.red     = red_q;
  assign bus.green   = green_q;
  assign bus.blue    = blue_q;

endmodule
